digit_match_ctrl: RTL and testbench
===================================

// Module: digit_match_ctrl
// PURPOSE
// Sequences the ten 1-bit x 4096 digit template pROMs (one 64x64 bitmap per digit) against the
// captured 64x64 sample bitmap, counting per-digit pixel agreement and reporting the best digit.
// Sits between the binarised-image sample buffer and the recognition result/display logic.
// Owns the shared template/sample read address and the per-ROM chip enables.
// PARAMETERS
// ADDR_W      12    template/sample address width; PIX = 2**ADDR_W pixels per bitmap
// NUM_DIGITS  10    number of template ROMs scanned, digit index 0..NUM_DIGITS-1
// MIN_SCORE   3072  minimum match count for result_valid=1
// PORTS
// clk           in   1            system clock
// rst_n         in   1            synchronous active-low reset
// start         in   1            one-cycle request to run a full match; ignored unless idle
// busy          out  1            high from cycle after accepted start until done cycle inclusive
// done          out  1            one-cycle pulse, result outputs updated same cycle
// result_digit  out  4            best-matching digit index
// result_score  out  ADDR_W+1     match count of best digit (0..PIX)
// result_valid  out  1            result_score >= MIN_SCORE
// ad            out  ADDR_W       shared read address to all template ROMs and sample buffer
// rom_ce        out  NUM_DIGITS   one-hot ROM chip enable, bit d = digit d being scanned
// rom_oce       out  1            constant 1
// rom_reset     out  1            = ~rst_n (pROM reset is sync active-high)
// rom_dout      in   NUM_DIGITS   bit d = dout of template ROM d
// smp_ce        out  1            sample buffer read enable
// smp_bit       in   1            sample buffer read data
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE; busy, done, result_*, ad, rom_ce, smp_ce all 0; counters 0.
// - ROM and sample reads: 1-cycle latency; data for address issued in cycle k is valid in cycle k+1.
// - FSM: IDLE -> FETCH -> DRAIN -> UPDATE -> (FETCH | DONE) -> IDLE.
// - IDLE: start=1 at cycle 0 -> FETCH from cycle 1, digit=0, ad=0, best_score=0, best_digit=0.
// - FETCH: rom_ce=one-hot(digit), smp_ce=1, ad increments by 1 each cycle 0..PIX-1; after
//   ad=PIX-1 -> DRAIN. Match pipeline: rd_vld register = (prev state FETCH); when rd_vld,
//   cnt += (rom_dout[digit] == smp_bit). rom_dout bits of unselected digits are ignored.
// - DRAIN: rom_ce=0, smp_ce=0, ad held; accumulates final pixel PIX-1.
// - UPDATE: if cnt > best_score (strict) then best_score=cnt, best_digit=digit; ties keep lower
//   index. cnt cleared, ad=0. digit==NUM_DIGITS-1 -> DONE else digit+1, -> FETCH.
// - DONE: done=1 one cycle; result_digit/score/valid registered from best_*; -> IDLE.
//   result_* hold until next done or reset.
// - Per-digit time PIX+2 cycles; start(cycle 0) -> done in cycle NUM_DIGITS*(PIX+2)+1 (40981).
// - cnt width ADDR_W+1; full match = PIX (4096) must not wrap.
// - start while busy: ignored, no restart. start in DONE cycle: ignored.
// - rst_n low mid-scan: immediate return to IDLE, partial counts discarded, result_* cleared.
// TESTING
// - Sample == template 3 bit-for-bit, others random -> done at cycle 40981, digit=3, score=4096, valid=1.
// - Templates 2 and 7 identical, sample equals both -> digit=2 (lower index on tie), score=4096.
// - All templates all-ones, sample all-zero -> digit=0, score=0, valid=0.
// - Sample differs from template 5 in exactly 1024 pixels, others worse -> digit=5, score=3072, valid=1.
// - start pulses at cycles 100 and 20000 during busy -> single done at 40981, busy never drops early.
// - rst_n low during digit 4 scan -> next edge: busy=0, rom_ce=0, result_*=0; fresh start completes normally.
// - Check ad sequence 0..4095 per digit, rom_ce one-hot tracking digit, smp_ce=0 in DRAIN/UPDATE.

Source files
------------

// File: rtl/digit_match_ctrl.sv
// Scans each digit template ROM against the captured sample bitmap, counts per-digit pixel
// agreement and reports the best-scoring digit (lowest index wins ties).
module digit_match_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int NUM_DIGITS = 10,
    parameter int MIN_SCORE  = 3072
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            result_digit,
    output logic [ADDR_W:0]       result_score,
    output logic                  result_valid,
    output logic [ADDR_W-1:0]     ad,
    output logic [NUM_DIGITS-1:0] rom_ce,
    output logic                  rom_oce,
    output logic                  rom_reset,
    input  logic [NUM_DIGITS-1:0] rom_dout,
    output logic                  smp_ce,
    input  logic                  smp_bit
);

    localparam logic [ADDR_W-1:0] LAST_AD     = '1;
    localparam logic [3:0]        LAST_DIGIT  = 4'(NUM_DIGITS - 1);
    localparam logic [ADDR_W:0]   MIN_SCORE_L = (ADDR_W + 1)'(MIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_digit;
    logic [ADDR_W-1:0]     r_ad;
    logic [NUM_DIGITS-1:0] r_rom_ce;
    logic                  r_smp_ce;
    logic                  r_rd_vld;
    logic [ADDR_W:0]       r_cnt;
    logic [ADDR_W:0]       r_best_score;
    logic [3:0]            r_best_digit;
    logic                  r_busy;
    logic                  r_done;
    logic [3:0]            r_result_digit;
    logic [ADDR_W:0]       r_result_score;
    logic                  r_result_valid;

    logic [NUM_DIGITS-1:0] w_digit_oh;
    logic [NUM_DIGITS-1:0] w_next_digit_oh;
    logic                  w_sel_bit;
    logic                  w_match;
    logic                  w_better;
    logic [ADDR_W:0]       w_new_best_score;
    logic [3:0]            w_new_best_digit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_dec
            assign w_digit_oh[gi]      = (r_digit == 4'(gi));
            assign w_next_digit_oh[gi] = ((r_digit + 4'd1) == 4'(gi));
        end
    endgenerate

    // Only the ROM of the digit being scanned contributes; other dout bits are don't-care.
    assign w_sel_bit        = |(rom_dout & w_digit_oh);
    assign w_match          = (w_sel_bit == smp_bit);
    assign w_better         = (r_cnt > r_best_score);
    assign w_new_best_score = w_better ? r_cnt : r_best_score;
    assign w_new_best_digit = w_better ? r_digit : r_best_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_digit        <= '0;
            r_ad           <= '0;
            r_rom_ce       <= '0;
            r_smp_ce       <= 1'b0;
            r_rd_vld       <= 1'b0;
            r_cnt          <= '0;
            r_best_score   <= '0;
            r_best_digit   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_digit <= '0;
            r_result_score <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= (r_state == S_FETCH);
            if (r_rd_vld) begin
                r_cnt <= r_cnt + (ADDR_W + 1)'(w_match);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_FETCH;
                        r_busy       <= 1'b1;
                        r_digit      <= '0;
                        r_ad         <= '0;
                        r_rom_ce     <= NUM_DIGITS'(1);
                        r_smp_ce     <= 1'b1;
                        r_cnt        <= '0;
                        r_best_score <= '0;
                        r_best_digit <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_ad == LAST_AD) begin
                        r_state  <= S_DRAIN;
                        r_rom_ce <= '0;
                        r_smp_ce <= 1'b0;
                    end else begin
                        r_ad <= r_ad + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_best_score <= w_new_best_score;
                    r_best_digit <= w_new_best_digit;
                    r_cnt        <= '0;
                    r_ad         <= '0;
                    if (r_digit == LAST_DIGIT) begin
                        // Results are loaded here so they are already valid during the done pulse.
                        r_state        <= S_DONE;
                        r_done         <= 1'b1;
                        r_result_digit <= w_new_best_digit;
                        r_result_score <= w_new_best_score;
                        r_result_valid <= (w_new_best_score >= MIN_SCORE_L);
                    end else begin
                        r_state  <= S_FETCH;
                        r_digit  <= r_digit + 4'd1;
                        r_rom_ce <= w_next_digit_oh;
                        r_smp_ce <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_digit = r_result_digit;
    assign result_score = r_result_score;
    assign result_valid = r_result_valid;
    assign ad           = r_ad;
    assign rom_ce       = r_rom_ce;
    assign smp_ce       = r_smp_ce;
    assign rom_oce      = 1'b1;
    assign rom_reset    = ~rst_n;

endmodule

// File: tb/tb_digit_match_ctrl.sv
// Scoreboard bench for digit_match_ctrl with behavioural template ROMs and sample buffer,
// run at a reduced bitmap size so that several full scans fit in a short simulation.
module tb_digit_match_ctrl;

    localparam int ADDR_W    = 8;
    localparam int PIX       = 2 ** ADDR_W;
    localparam int ND        = 10;
    localparam int MINS      = (3 * PIX) / 4;
    localparam int SCAN_END  = ND * (PIX + 2);
    localparam int DONE_LAT  = SCAN_END + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        result_digit;
    logic [ADDR_W:0]   result_score;
    logic              result_valid;
    logic [ADDR_W-1:0] ad;
    logic [ND-1:0]     rom_ce;
    logic              rom_oce;
    logic              rom_reset;
    logic [ND-1:0]     rom_dout;
    logic              smp_ce;
    logic              smp_bit;

    digit_match_ctrl #(
        .ADDR_W    (ADDR_W),
        .NUM_DIGITS(ND),
        .MIN_SCORE (MINS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result_digit(result_digit),
        .result_score(result_score),
        .result_valid(result_valid),
        .ad          (ad),
        .rom_ce      (rom_ce),
        .rom_oce     (rom_oce),
        .rom_reset   (rom_reset),
        .rom_dout    (rom_dout),
        .smp_ce      (smp_ce),
        .smp_bit     (smp_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int digit;
        int score;
        int valid;
    } exp_t;

    bit   tmpl   [ND][PIX];
    bit   sample [PIX];
    exp_t sb_q   [$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   t0     = 0;
    bit   mon_en = 1'b0;
    int   mon_c, mon_idx, mon_off;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s: got %0d expected %0d (cycle offset %0d)", tag, obs, exp_v, cyc - t0);
        end
    endtask

    // Behavioural pROMs and sample buffer: one-cycle read latency, output held when not enabled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < ND; d++)
            if (rom_ce[d]) rom_dout[d] <= tmpl[d][ad];
        if (smp_ce) smp_bit <= sample[ad];
    end

    function automatic exp_t model();
        exp_t r;
        int   cnt;
        r.digit = 0;
        r.score = 0;
        for (int d = 0; d < ND; d++) begin
            cnt = 0;
            for (int p = 0; p < PIX; p++) cnt += (tmpl[d][p] == sample[p]) ? 1 : 0;
            if (cnt > r.score) begin
                r.score = cnt;
                r.digit = d;
            end
        end
        r.valid = (r.score >= MINS) ? 1 : 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon_c = cyc - t0;
            if (mon_c >= 1 && mon_c <= DONE_LAT + 4) begin
                chk("busy", busy, mon_c <= DONE_LAT);
                chk("done", done, mon_c == DONE_LAT);
                if (mon_c <= SCAN_END) begin
                    mon_idx = (mon_c - 1) / (PIX + 2);
                    mon_off = (mon_c - 1) % (PIX + 2);
                    if (mon_off < PIX) begin
                        chk("smp_ce_fetch", smp_ce, 1);
                        chk("rom_ce_fetch", rom_ce, 1 << mon_idx);
                        chk("ad_fetch", ad, mon_off);
                    end else begin
                        chk("smp_ce_gap", smp_ce, 0);
                        chk("rom_ce_gap", rom_ce, 0);
                    end
                end
                if (done && sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result_digit", result_digit, e.digit);
                    chk("result_score", result_score, e.score);
                    chk("result_valid", result_valid, e.valid);
                    $display("scan done: digit=%0d score=%0d valid=%0d (exp %0d/%0d/%0d)",
                             result_digit, result_score, result_valid, e.digit, e.score, e.valid);
                end
            end
        end
    end

    // Entered and left on a negedge; stray start pulses land mid-scan and in the done cycle.
    task automatic run_scan(input string name, input bit extra_starts);
        sb_q.push_back(model());
        $display("scan '%s' started", name);
        t0     = cyc;
        mon_en = 1'b1;
        for (int c = 0; c <= DONE_LAT + 4; c++) begin
            start = (c == 0) || (extra_starts && (c == 100 || c == 2000 || c == DONE_LAT));
            @(negedge clk);
        end
        start  = 1'b0;
        mon_en = 1'b0;
        if (sb_q.size() != 0) begin
            chk("done_seen", 0, 1);
            sb_q.delete();
        end
    endtask

    task automatic fill_random();
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < PIX; p++) tmpl[d][p] = 1'($urandom);
        for (int p = 0; p < PIX; p++) sample[p] = 1'($urandom);
    endtask

    // Template d becomes the sample with exactly k distinct pixels inverted.
    task automatic set_near(input int d, input int k);
        for (int p = 0; p < PIX; p++) tmpl[d][p] = sample[p];
        for (int i = 0; i < k; i++) tmpl[d][(i * 37) % PIX] = ~sample[(i * 37) % PIX];
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ad"}, ad, 0);
        chk({tag, "_rom_ce"}, rom_ce, 0);
        chk({tag, "_smp_ce"}, smp_ce, 0);
        chk({tag, "_res_digit"}, result_digit, 0);
        chk({tag, "_res_score"}, result_score, 0);
        chk({tag, "_res_valid"}, result_valid, 0);
        chk({tag, "_rom_reset"}, rom_reset, 1);
        chk({tag, "_rom_oce"}, rom_oce, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rom_dout = '0;
        smp_bit  = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rom_reset_run", rom_reset, 0);

        fill_random();
        set_near(3, 0);
        run_scan("exact_match_3", 1'b0);
        run_scan("starts_while_busy", 1'b1);

        fill_random();
        set_near(2, 0);
        set_near(7, 0);
        run_scan("tie_2_7", 1'b0);

        for (int d = 0; d < ND; d++)
            for (int p = 0; p < PIX; p++) tmpl[d][p] = 1'b1;
        for (int p = 0; p < PIX; p++) sample[p] = 1'b0;
        run_scan("all_mismatch", 1'b0);

        fill_random();
        set_near(5, PIX / 4);
        run_scan("threshold_exact", 1'b0);
        set_near(5, PIX / 4 + 1);
        run_scan("threshold_below", 1'b0);

        fill_random();
        set_near(3, 0);
        $display("scan 'reset_mid_digit4' started");
        t0    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * (PIX + 2) + 49) @(negedge clk);
        chk("rom_ce_digit4", rom_ce, 1 << 4);
        chk("busy_digit4", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        run_scan("after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
